lbm_result_reader: RTL and testbench

- Reader side of the LBM_DE2 result memories: after a simulation run completes, walks every grid cell in address order.
- For each cell, reads density (p), x-velocity (ux) and y-velocity (uy) through the core's `*_mem_data_out` ports.
- Emits the three words per cell on a valid/ready stream toward the host/readout path (UART or JTAG bridge).
- Sits between the LBM core's result RAMs and the board-level readout logic.

---
 rtl/lbm_result_reader_if.sv | 52 +++++
 rtl/lbm_result_reader.sv | 211 +++++++++++++++++++++
 tb/tb_lbm_result_reader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lbm_result_reader_if.sv
// -----------------------------------------------------------------------------
// lbm_result_reader_if
//   Bundles the signals between the result reader, the LBM core's result RAMs
//   and the downstream readout path (UART / JTAG bridge).
//
//   Signals:
//     start              core -> reader   run finished, begin readout
//     busy, done         reader -> core   readout status / completion pulse
//     mem_rd_en/addr     reader -> RAMs   synchronous read, 1-cycle latency
//     *_mem_data_out     RAMs -> reader   p / ux / uy words
//     out_data/sel/last  reader -> host   stream payload, tag, end of frame
//     out_valid/ready    stream handshake
//     dbg_state          reader FSM state, for observation only
//
//   Handshake: a word transfers on every rising clock edge where out_valid and
//   out_ready are both 1. Once out_valid rises it stays high, and out_data,
//   out_sel and out_last stay stable, until that transfer happens. out_ready
//   may change freely and never combinationally depends on out_valid.
//
//   Modports: master = the reader, slave = the environment around it.
// -----------------------------------------------------------------------------
interface lbm_result_reader_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 8
);
   logic                     start;
   logic                     busy;
   logic                     done;
   logic                     mem_rd_en;
   logic [ADDRESS_WIDTH-1:0] mem_rd_addr;
   logic [DATA_WIDTH-1:0]    p_mem_data_out;
   logic [DATA_WIDTH-1:0]    ux_mem_data_out;
   logic [DATA_WIDTH-1:0]    uy_mem_data_out;
   logic [DATA_WIDTH-1:0]    out_data;
   logic [1:0]               out_sel;
   logic                     out_valid;
   logic                     out_ready;
   logic                     out_last;
   logic [2:0]               dbg_state;

   modport master (
      input  start, p_mem_data_out, ux_mem_data_out, uy_mem_data_out, out_ready,
      output busy, done, mem_rd_en, mem_rd_addr,
             out_data, out_sel, out_valid, out_last, dbg_state
   );

   modport slave (
      output start, p_mem_data_out, ux_mem_data_out, uy_mem_data_out, out_ready,
      input  busy, done, mem_rd_en, mem_rd_addr,
             out_data, out_sel, out_valid, out_last, dbg_state
   );
endinterface

// File: rtl/lbm_result_reader.sv
// -----------------------------------------------------------------------------
// lbm_result_reader
//   After an LBM run completes, walks every grid cell in address order, reads
//   density (p), x-velocity (ux) and y-velocity (uy) from the result RAMs and
//   streams the three words per cell (tag 0, 1, 2) on a valid/ready stream.
//   Words are passed bit-exact; the signed 8.24 format is never interpreted.
//
//   Ports:
//     CLOCK_50  system clock
//     RESET     asynchronous, active-high reset; aborts any frame in progress
//     bus       lbm_result_reader_if.master (start/busy/done, RAM read port,
//               output stream, dbg_state)
//
//   Optional feature (macro LBM_READER_CHECKSUM_EN):
//     When defined, every accepted word is summed modulo 2^DATA_WIDTH and an
//     extra word with tag 3 carrying that sum closes the frame; out_last then
//     marks the checksum word instead of the final uy word.
//
//   Per cell with out_ready held high: READ, CAPTURE, EMIT_P, EMIT_UX, EMIT_UY
//   = 5 cycles. All outputs are registered and updated on state transitions.
// -----------------------------------------------------------------------------
module lbm_result_reader #(
   parameter int GRID_DIM      = 256,
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = $clog2(GRID_DIM)
) (
   input  logic               CLOCK_50,
   input  logic               RESET,
   lbm_result_reader_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_CAPTURE = 3'd2,
      S_EMIT_P  = 3'd3,
      S_EMIT_UX = 3'd4,
      S_EMIT_UY = 3'd5,
      S_DONE    = 3'd6
`ifdef LBM_READER_CHECKSUM_EN
      ,
      S_CSUM    = 3'd7
`endif
   } state_t;

   // Explicit compare value so non-power-of-two grids never rely on wrap.
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(GRID_DIM - 1);

   state_t                   state;
   logic [ADDRESS_WIDTH-1:0] counter;
   logic [DATA_WIDTH-1:0]    ux_reg;
   logic [DATA_WIDTH-1:0]    uy_reg;
   logic                     busy_r;
   logic                     done_r;
   logic                     rd_en_r;
   logic [ADDRESS_WIDTH-1:0] rd_addr_r;
   logic [DATA_WIDTH-1:0]    out_data_r;
   logic [1:0]               out_sel_r;
   logic                     out_valid_r;
   logic                     out_last_r;
`ifdef LBM_READER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]    csum;
`endif

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state       <= S_IDLE;
         counter     <= '0;
         ux_reg      <= '0;
         uy_reg      <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         rd_en_r     <= 1'b0;
         rd_addr_r   <= '0;
         out_data_r  <= '0;
         out_sel_r   <= 2'd0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
`ifdef LBM_READER_CHECKSUM_EN
         csum        <= '0;
`endif
      end else begin
         // Single-cycle strobes; re-asserted below only where needed.
         done_r  <= 1'b0;
         rd_en_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state     <= S_READ;
                  counter   <= '0;
                  busy_r    <= 1'b1;
                  rd_en_r   <= 1'b1;
                  rd_addr_r <= '0;
`ifdef LBM_READER_CHECKSUM_EN
                  csum      <= '0;
`endif
               end
            end

            S_READ: begin
               state <= S_CAPTURE;
            end

            S_CAPTURE: begin
               // RAM data is valid now; p goes straight into the output
               // register, ux/uy wait in their capture registers.
               ux_reg      <= bus.ux_mem_data_out;
               uy_reg      <= bus.uy_mem_data_out;
               out_data_r  <= bus.p_mem_data_out;
               out_sel_r   <= 2'd0;
               out_valid_r <= 1'b1;
               out_last_r  <= 1'b0;
               state       <= S_EMIT_P;
            end

            S_EMIT_P: begin
               if (bus.out_ready) begin
`ifdef LBM_READER_CHECKSUM_EN
                  csum <= csum + out_data_r;
`endif
                  out_data_r <= ux_reg;
                  out_sel_r  <= 2'd1;
                  state      <= S_EMIT_UX;
               end
            end

            S_EMIT_UX: begin
               if (bus.out_ready) begin
`ifdef LBM_READER_CHECKSUM_EN
                  csum       <= csum + out_data_r;
                  out_last_r <= 1'b0;
`else
                  out_last_r <= (counter == LAST_ADDR);
`endif
                  out_data_r <= uy_reg;
                  out_sel_r  <= 2'd2;
                  state      <= S_EMIT_UY;
               end
            end

            S_EMIT_UY: begin
               if (bus.out_ready) begin
                  if (counter == LAST_ADDR) begin
`ifdef LBM_READER_CHECKSUM_EN
                     // Sum includes the uy word being accepted on this edge.
                     out_data_r <= csum + out_data_r;
                     out_sel_r  <= 2'd3;
                     out_last_r <= 1'b1;
                     state      <= S_CSUM;
`else
                     out_valid_r <= 1'b0;
                     out_data_r  <= '0;
                     out_sel_r   <= 2'd0;
                     out_last_r  <= 1'b0;
                     done_r      <= 1'b1;
                     state       <= S_DONE;
`endif
                  end else begin
`ifdef LBM_READER_CHECKSUM_EN
                     csum <= csum + out_data_r;
`endif
                     counter     <= counter + 1'b1;
                     rd_addr_r   <= counter + 1'b1;
                     rd_en_r     <= 1'b1;
                     out_valid_r <= 1'b0;
                     out_data_r  <= '0;
                     out_sel_r   <= 2'd0;
                     out_last_r  <= 1'b0;
                     state       <= S_READ;
                  end
               end
            end

`ifdef LBM_READER_CHECKSUM_EN
            S_CSUM: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  out_data_r  <= '0;
                  out_sel_r   <= 2'd0;
                  out_last_r  <= 1'b0;
                  done_r      <= 1'b1;
                  state       <= S_DONE;
               end
            end
`endif

            S_DONE: begin
               // start is deliberately not looked at here.
               busy_r    <= 1'b0;
               rd_addr_r <= '0;
               state     <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.mem_rd_en   = rd_en_r;
   assign bus.mem_rd_addr = rd_addr_r;
   assign bus.out_data    = out_data_r;
   assign bus.out_sel     = out_sel_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_last    = out_last_r;
   assign bus.dbg_state   = state;

endmodule

// File: tb/tb_lbm_result_reader.sv
// -----------------------------------------------------------------------------
// tb_lbm_result_reader
//   Bench for lbm_result_reader with GRID_DIM=4. A result-RAM model returns
//   p=addr, ux=addr+100, uy=addr+200 one cycle after a read strobe. The
//   expected frame is built from those RAM contents into exp_q and the DUT
//   stream is compared against it every cycle. Honours LBM_READER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_lbm_result_reader;
   localparam int GRID_DIM      = 4;
   localparam int DATA_WIDTH    = 32;
   localparam int ADDRESS_WIDTH = 2;
   localparam int W             = DATA_WIDTH + 3;   // {last, sel[1:0], data}

`ifdef LBM_READER_CHECKSUM_EN
   localparam logic [W-1:0] LAST_WORD_A = {1'b1, 2'd3, 32'h0000_04C2};
   localparam logic [W-1:0] LAST_WORD_B = {1'b1, 2'd3, 32'hFF00_04C2};
`else
   localparam logic [W-1:0] LAST_WORD_A = {1'b1, 2'd2, 32'd203};
   localparam logic [W-1:0] LAST_WORD_B = {1'b1, 2'd2, 32'd203};
`endif

   // ---------------- clock / reset ----------------
   logic CLOCK_50 = 1'b0;
   logic RESET    = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   lbm_result_reader_if #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) bus ();

   lbm_result_reader #(
      .GRID_DIM(GRID_DIM), .DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .RESET(RESET),
      .bus(bus)
   );

   // ---------------- result RAM model ----------------
   logic [DATA_WIDTH-1:0] ram_p  [GRID_DIM];
   logic [DATA_WIDTH-1:0] ram_ux [GRID_DIM];
   logic [DATA_WIDTH-1:0] ram_uy [GRID_DIM];

   always @(posedge CLOCK_50) begin
      if (bus.mem_rd_en) begin
         bus.p_mem_data_out  <= ram_p[bus.mem_rd_addr];
         bus.ux_mem_data_out <= ram_ux[bus.mem_rd_addr];
         bus.uy_mem_data_out <= ram_uy[bus.mem_rd_addr];
      end
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_popped = '0;
   logic [ADDRESS_WIDTH-1:0] exp_addr = '0;
   logic done_due = 1'b0;
   bit   checking = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Compare process: stream words, read addresses and the done pulse.
   always @(negedge CLOCK_50) begin
      if (checking && !RESET) begin
         check("done_pulse", {63'd0, bus.done}, {63'd0, done_due});
         done_due = 1'b0;
         if (bus.mem_rd_en) begin
            check("rd_addr", {62'd0, bus.mem_rd_addr}, {62'd0, exp_addr});
            check("rd_while_valid", {63'd0, bus.out_valid}, 64'd0);
            exp_addr = exp_addr + 1'b1;
         end
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_word actual=%0h required=none t=%0t",
                        {bus.out_last, bus.out_sel, bus.out_data}, $time);
            end else begin
               check("word", {29'd0, bus.out_last, bus.out_sel, bus.out_data}, {29'd0, exp_q[0]});
               if (bus.out_ready) begin
                  last_popped = exp_q[0];
                  if (exp_q[0][W-1]) done_due = 1'b1;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},  {63'd0, bus.busy},      64'd0);
      check({tag, "_done"},  {63'd0, bus.done},      64'd0);
      check({tag, "_rd_en"}, {63'd0, bus.mem_rd_en}, 64'd0);
      check({tag, "_addr"},  {62'd0, bus.mem_rd_addr}, 64'd0);
      check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd0);
      check({tag, "_data"},  {32'd0, bus.out_data},  64'd0);
      check({tag, "_sel"},   {62'd0, bus.out_sel},   64'd0);
      check({tag, "_last"},  {63'd0, bus.out_last},  64'd0);
   endtask

   // Builds the expected frame from the RAM contents, pulses start and pins
   // the start-to-first-word latency.
   task automatic start_frame(input logic [DATA_WIDTH-1:0] first_word);
      logic [DATA_WIDTH-1:0] sum;
      bit last_uy;
      sum = '0;
      exp_q.delete();
      exp_addr = '0;
      for (int a = 0; a < GRID_DIM; a++) begin
`ifdef LBM_READER_CHECKSUM_EN
         last_uy = 1'b0;
`else
         last_uy = (a == GRID_DIM - 1);
`endif
         exp_q.push_back({1'b0, 2'd0, ram_p[a]});
         exp_q.push_back({1'b0, 2'd1, ram_ux[a]});
         exp_q.push_back({last_uy, 2'd2, ram_uy[a]});
         sum = sum + ram_p[a] + ram_ux[a] + ram_uy[a];
      end
`ifdef LBM_READER_CHECKSUM_EN
      exp_q.push_back({1'b1, 2'd3, sum});
`endif
      @(posedge CLOCK_50); #1 bus.start = 1'b1;
      @(posedge CLOCK_50); #1 bus.start = 1'b0;
      @(negedge CLOCK_50);
      check("lat1_valid", {63'd0, bus.out_valid}, 64'd0);
      check("lat1_rd_en", {63'd0, bus.mem_rd_en}, 64'd1);
      check("lat1_addr",  {62'd0, bus.mem_rd_addr}, 64'd0);
      check("lat1_busy",  {63'd0, bus.busy}, 64'd1);
      @(negedge CLOCK_50);
      check("lat2_valid", {63'd0, bus.out_valid}, 64'd0);
      @(negedge CLOCK_50);
      check("lat3_valid", {63'd0, bus.out_valid}, 64'd1);
      check("lat3_data",  {32'd0, bus.out_data}, {32'd0, first_word});
      check("lat3_sel",   {62'd0, bus.out_sel}, 64'd0);
   endtask

   task automatic finish_frame(input logic [W-1:0] last_expect);
      int n;
      n = 0;
      while (!bus.done && n < 300) begin
         @(negedge CLOCK_50);
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=no_done required=done within 300 cycles");
      end
      check("done_busy",      {63'd0, bus.busy}, 64'd1);
      check("queue_drained",  64'(exp_q.size()), 64'd0);
      check("last_word",      {29'd0, last_popped}, {29'd0, last_expect});
      @(negedge CLOCK_50);
      check("idle_busy", {63'd0, bus.busy}, 64'd0);
      check("idle_addr", {62'd0, bus.mem_rd_addr}, 64'd0);
   endtask

   task automatic wait_read_of(input int addr);
      int n;
      n = 0;
      do begin
         @(posedge CLOCK_50); #1;
         n++;
      end while (!(bus.mem_rd_en && bus.mem_rd_addr == ADDRESS_WIDTH'(addr)) && n < 100);
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL read_timeout actual=no_read required=read of addr %0d", addr);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < GRID_DIM; i++) begin
         ram_p[i]  = DATA_WIDTH'(i);
         ram_ux[i] = DATA_WIDTH'(i + 100);
         ram_uy[i] = DATA_WIDTH'(i + 200);
      end

      // Reset asserted between edges with start held high.
      bus.start = 1'b1;
      #3 RESET = 1'b1;
      #1 check_idle_outputs("reset_async");
      repeat (2) @(posedge CLOCK_50);
      #3 RESET = 1'b0;
      bus.start = 1'b0;
      @(negedge CLOCK_50);
      check("busy_after_reset", {63'd0, bus.busy}, 64'd0);
      checking = 1'b1;

      // Frame 1: full frame, ready held high.
      start_frame(32'd0);
      finish_frame(LAST_WORD_A);

      // Frame 2: backpressure on ux of cell 1, start pulsed during cell 2.
      start_frame(32'd0);
      n = 0;
      do begin
         @(posedge CLOCK_50); #1;
         n++;
      end while (!(bus.out_valid && bus.out_sel == 2'd1 && bus.out_data == 32'd101) && n < 100);
      bus.out_ready = 1'b0;
      repeat (5) begin
         @(negedge CLOCK_50);
         check("bp_data",  {32'd0, bus.out_data}, 64'd101);
         check("bp_sel",   {62'd0, bus.out_sel}, 64'd1);
         check("bp_valid", {63'd0, bus.out_valid}, 64'd1);
         check("bp_rd_en", {63'd0, bus.mem_rd_en}, 64'd0);
      end
      @(posedge CLOCK_50); #1 bus.out_ready = 1'b1;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      check("bp_resume_data", {32'd0, bus.out_data}, 64'd201);
      check("bp_resume_sel",  {62'd0, bus.out_sel}, 64'd2);
      wait_read_of(2);
      bus.start = 1'b1;
      @(posedge CLOCK_50); #1 bus.start = 1'b0;
      finish_frame(LAST_WORD_A);

      // Frame 3: identical frame after done.
      start_frame(32'd0);
      finish_frame(LAST_WORD_A);

      // Frame 4: reset while cell 2 is being read, then restart.
      start_frame(32'd0);
      wait_read_of(2);
      #2;
      bus.start = 1'b1;
      RESET     = 1'b1;
      #1 check_idle_outputs("reset_mid");
      exp_q.delete();
      done_due = 1'b0;
      @(posedge CLOCK_50);
      #3 RESET = 1'b0;
      bus.start = 1'b0;
      repeat (4) begin
         @(negedge CLOCK_50);
         check("post_reset_busy", {63'd0, bus.busy}, 64'd0);
      end

      // Frame 5: signed word passed bit-exact, restart from address 0.
      ram_p[0] = 32'hFF00_0000;
      start_frame(32'hFF00_0000);
      finish_frame(LAST_WORD_B);

      repeat (3) @(negedge CLOCK_50);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
